// File: rtl/sort_sequencer_pkg.sv
// Shared decode constants, FSM state type and SORT decode helper for the control unit.
package sort_sequencer_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned MODE_W = 2;
    localparam int unsigned CNT_W  = 16;

    localparam logic [OP_W-1:0]   SORT_OPCODE = 4'b0111;
    localparam logic [MODE_W-1:0] MODE_ARITH  = 2'b00;

    typedef enum logic {
        IDLE = 1'b0,
        PH1  = 1'b1
    } sort_state_e;

    // A SORT is a live, condition-passing arithmetic-mode instruction with the SORT opcode.
    function automatic logic decode_sort(input logic              valid,
                                         input logic [MODE_W-1:0] mode,
                                         input logic [OP_W-1:0]   op_code,
                                         input logic              cond_pass);
        return valid & (mode == MODE_ARITH) & (op_code == SORT_OPCODE) & cond_pass;
    endfunction

endpackage

// File: rtl/sort_sequencer_if.sv
// ID-stage SORT control bundle: pipeline side drives the instruction/stall inputs,
// the sequencer returns phase, freeze and status.
interface sort_sequencer_if;
    import sort_sequencer_pkg::*;

    logic              instr_valid;
    logic [OP_W-1:0]   op_code;
    logic [MODE_W-1:0] mode;
    logic              cond_pass;
    logic              hazard;
    logic              flush;
    logic              sort_phase;
    logic              freeze;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  sort_count;

    modport master (
        output instr_valid, op_code, mode, cond_pass, hazard, flush,
        input  sort_phase, freeze, busy, done, sort_count
    );

    modport slave (
        input  instr_valid, op_code, mode, cond_pass, hazard, flush,
        output sort_phase, freeze, busy, done, sort_count
    );

endinterface

// File: rtl/sort_sequencer_sat_counter16.sv
// 16-bit counter that increments on inc and sticks at all-ones instead of wrapping.
module sat_counter16
    import sort_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sort_sequencer.sv
// Two-phase SORT issue sequencer: phase 0 writes min to Rd while freezing fetch,
// phase 1 writes max to Rn; hazard stalls either phase, flush kills the SORT.
module sort_sequencer
    import sort_sequencer_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    sort_sequencer_if.slave ctl
);

    sort_state_e state_q;
    sort_state_e state_d;

    logic is_sort_c;
    logic sort_phase_c;
    logic freeze_c;
    logic busy_c;
    logic done_c;

    assign is_sort_c = decode_sort(ctl.instr_valid, ctl.mode, ctl.op_code, ctl.cond_pass);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // cond_pass only matters in IDLE; once in PH1 the SORT completes regardless of SR.
    always_comb begin
        state_d      = state_q;
        sort_phase_c = 1'b0;
        freeze_c     = 1'b0;
        busy_c       = 1'b0;
        done_c       = 1'b0;
        case (state_q)
            IDLE: begin
                freeze_c = is_sort_c & ~ctl.flush;
                if (is_sort_c & ~ctl.hazard & ~ctl.flush) begin
                    state_d = PH1;
                end
            end
            PH1: begin
                sort_phase_c = 1'b1;
                busy_c       = 1'b1;
                freeze_c     = ctl.hazard & ~ctl.flush;
                done_c       = ~ctl.hazard & ~ctl.flush;
                if (~ctl.hazard | ctl.flush) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    sat_counter16 u_count (
        .clk   (clk),
        .rst   (rst),
        .inc   (done_c),
        .count (ctl.sort_count)
    );

    assign ctl.sort_phase = sort_phase_c;
    assign ctl.freeze     = freeze_c;
    assign ctl.busy       = busy_c;
    assign ctl.done       = done_c;

endmodule

// File: tb/tb_sort_sequencer.sv
// Self-checking bench for sort_sequencer: directed cycle table, async reset and
// saturation sequences, then randomized traffic against a behavioural model.
module tb_sort_sequencer;

    logic clk;
    logic rst;

    sort_sequencer_if bus ();

    sort_sequencer dut (
        .clk (clk),
        .rst (rst),
        .ctl (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_fail;

    typedef struct {
        logic       v;
        logic [3:0] op;
        logic [1:0] md;
        logic       cp;
        logic       h;
        logic       f;
        logic       efz;
        logic       eph;
        logic       eb;
        logic       ed;
        logic [15:0] ecnt;
    } vec_t;

    localparam int NVEC = 26;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic v, input logic [3:0] op, input logic [1:0] md,
                                input logic cp, input logic h, input logic f,
                                input logic efz, input logic eph, input logic eb,
                                input logic ed, input logic [15:0] c);
        vec_t r;
        r.v = v; r.op = op; r.md = md; r.cp = cp; r.h = h; r.f = f;
        r.efz = efz; r.eph = eph; r.eb = eb; r.ed = ed; r.ecnt = c;
        return r;
    endfunction

    task automatic chk1(input string nm, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [1:0] md,
                         input logic cp, input logic h, input logic f);
        bus.instr_valid = v;
        bus.op_code     = op;
        bus.mode        = md;
        bus.cond_pass   = cp;
        bus.hazard      = h;
        bus.flush       = f;
    endtask

    task automatic check_all(input string nm, input logic efz, input logic eph,
                             input logic eb, input logic ed, input logic [15:0] ecnt);
        chk1({nm, " freeze"}, bus.freeze, efz);
        chk1({nm, " sort_phase"}, bus.sort_phase, eph);
        chk1({nm, " busy"}, bus.busy, eb);
        chk1({nm, " done"}, bus.done, ed);
        chk16({nm, " sort_count"}, bus.sort_count, ecnt);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Reference: a SORT occupies phase 0 until it issues, then phase 1 until it issues;
    // hazard stalls the current phase, flush discards the SORT outright.
    bit          m_in_ph1;
    int unsigned m_sorts;

    task automatic model_cycle(input logic v, input logic [3:0] op, input logic [1:0] md,
                               input logic cp, input logic h, input logic f,
                               output logic efz, output logic eph, output logic eb,
                               output logic ed);
        bit sort_seen;
        sort_seen = v && (md == 2'd0) && (op == 4'd7) && cp;
        eph = m_in_ph1;
        eb  = m_in_ph1;
        if (m_in_ph1) begin
            ed  = !h && !f;
            efz = h && !f;
            m_in_ph1 = h && !f;
        end else begin
            ed  = 1'b0;
            efz = sort_seen && !f;
            m_in_ph1 = sort_seen && !h && !f;
        end
    endtask

    initial begin
        logic efz, eph, eb, ed;
        logic [15:0] exp_cnt;
        n_checks = 0;
        n_fail   = 0;
        m_in_ph1 = 1'b0;
        m_sorts  = 0;

        tbl[0]  = mk(1, 4'd7, 2'd0, 1, 0, 0, 1, 0, 0, 0, 16'd0);
        tbl[1]  = mk(0, 4'd0, 2'd0, 0, 0, 0, 0, 1, 1, 1, 16'd0);
        tbl[2]  = mk(0, 4'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 16'd1);
        tbl[3]  = mk(1, 4'd7, 2'd0, 1, 1, 0, 1, 0, 0, 0, 16'd1);
        tbl[4]  = mk(1, 4'd7, 2'd0, 1, 1, 0, 1, 0, 0, 0, 16'd1);
        tbl[5]  = mk(1, 4'd7, 2'd0, 1, 0, 0, 1, 0, 0, 0, 16'd1);
        tbl[6]  = mk(0, 4'd0, 2'd0, 0, 1, 0, 1, 1, 1, 0, 16'd1);
        tbl[7]  = mk(0, 4'd0, 2'd0, 0, 0, 0, 0, 1, 1, 1, 16'd1);
        tbl[8]  = mk(1, 4'd7, 2'd0, 1, 0, 0, 1, 0, 0, 0, 16'd2);
        tbl[9]  = mk(0, 4'd0, 2'd0, 0, 0, 1, 0, 1, 1, 0, 16'd2);
        tbl[10] = mk(0, 4'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 16'd2);
        tbl[11] = mk(1, 4'd7, 2'd0, 1, 1, 1, 0, 0, 0, 0, 16'd2);
        tbl[12] = mk(0, 4'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 16'd2);
        tbl[13] = mk(1, 4'd7, 2'd0, 0, 0, 0, 0, 0, 0, 0, 16'd2);
        tbl[14] = mk(1, 4'd4, 2'd0, 1, 0, 0, 0, 0, 0, 0, 16'd2);
        tbl[15] = mk(1, 4'd7, 2'd1, 1, 0, 0, 0, 0, 0, 0, 16'd2);
        tbl[16] = mk(0, 4'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 16'd2);
        tbl[17] = mk(1, 4'd7, 2'd0, 1, 0, 0, 1, 0, 0, 0, 16'd2);
        tbl[18] = mk(1, 4'd7, 2'd0, 1, 0, 0, 0, 1, 1, 1, 16'd2);
        tbl[19] = mk(1, 4'd7, 2'd0, 1, 0, 0, 1, 0, 0, 0, 16'd3);
        tbl[20] = mk(1, 4'd7, 2'd0, 0, 1, 0, 1, 1, 1, 0, 16'd3);
        tbl[21] = mk(1, 4'd7, 2'd0, 0, 0, 0, 0, 1, 1, 1, 16'd3);
        tbl[22] = mk(0, 4'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 16'd4);
        tbl[23] = mk(1, 4'd7, 2'd0, 1, 0, 0, 1, 0, 0, 0, 16'd4);
        tbl[24] = mk(0, 4'd0, 2'd0, 0, 1, 1, 0, 1, 1, 0, 16'd4);
        tbl[25] = mk(0, 4'd0, 2'd0, 0, 0, 0, 0, 0, 0, 0, 16'd4);

        // Reset state, observed before any clock edge.
        rst = 1'b1;
        drive(1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        #2;
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cycle table.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].op, tbl[i].md, tbl[i].cp, tbl[i].h, tbl[i].f);
            #1;
            check_all($sformatf("row%0d", i), tbl[i].efz, tbl[i].eph, tbl[i].eb,
                      tbl[i].ed, tbl[i].ecnt);
        end

        // Async reset in the middle of PH1: no done, count cleared without a clock edge.
        @(negedge clk);
        drive(1'b1, 4'd7, 2'd0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
        #1;
        chk1("midph1 busy before rst", bus.busy, 1'b1);
        rst = 1'b1;
        #1;
        check_all("midph1 rst", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_all("post rst idle", 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);

        // Saturation: preload near the top, then three SORTs.
        @(negedge clk);
        dut.u_count.count_q <= 16'hFFFE;
        #1;
        chk16("preload", bus.sort_count, 16'hFFFE);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            drive(1'b1, 4'd7, 2'd0, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            drive(1'b0, 4'h0, 2'b00, 1'b0, 1'b0, 1'b0);
            #1;
            chk1($sformatf("sat%0d done", k), bus.done, 1'b1);
            @(negedge clk);
            #1;
            chk16($sformatf("sat%0d count", k), bus.sort_count, 16'hFFFF);
        end

        // Randomized traffic against the model.
        do_reset();
        m_in_ph1 = 1'b0;
        m_sorts  = 0;
        for (int c = 0; c < 400; c++) begin
            logic       v, cp, h, f;
            logic [3:0] op;
            logic [1:0] md;
            @(negedge clk);
            v  = ($urandom_range(0, 4) != 0);
            op = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd7;
            md = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'd0;
            cp = ($urandom_range(0, 4) != 0);
            h  = ($urandom_range(0, 9) < 3);
            f  = ($urandom_range(0, 9) < 1);
            drive(v, op, md, cp, h, f);
            exp_cnt = (m_sorts > 32'd65535) ? 16'hFFFF : 16'(m_sorts);
            model_cycle(v, op, md, cp, h, f, efz, eph, eb, ed);
            #1;
            check_all($sformatf("rnd%0d", c), efz, eph, eb, ed, exp_cnt);
            if (ed) m_sorts++;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sort_sequencer.md
SORT_SEQUENCER -- requirements
Module: sort_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock shared with the pipeline.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 instr_valid  input  1  the IF/ID register holds a real (non-bubble) instruction.
REQ-005 op_code  input  4  Instruction[24:21] of the ID instruction.
REQ-006 mode  input  2  Instruction[27:26] of the ID instruction.
REQ-007 cond_pass  input  1  the condition-check result for the ID instruction.
REQ-008 hazard  input  1  data-hazard stall from the hazard unit.
REQ-009 flush  input  1  taken branch in EXE; kills the ID instruction.
REQ-010 sort_phase  output  1  0 = writes min to Rd; 1 = writes max to Rn (this signal drives the ID Dest mux).
REQ-011 freeze  output  1  holds the PC and the IF/ID register this cycle.
REQ-012 busy  output  1  high while in state PH1.
REQ-013 done  output  1  one-cycle pulse when phase 1 issues to ID/EX.
REQ-014 sort_count  output  16  saturating count of completed SORTs.

Function
REQ-015 The block SHALL decode is_sort = instr_valid & (mode == 2'b00) & (op_code == SORT_OPCODE) & cond_pass, where SORT_OPCODE = 4'b0111.
REQ-016 The FSM SHALL have exactly two states, IDLE and PH1, with a registered state and combinational outputs.
REQ-017 In IDLE, sort_phase SHALL be 0 and busy SHALL be 0.
REQ-018 In IDLE, freeze SHALL equal is_sort & ~flush.
REQ-019 IDLE SHALL go to PH1 when is_sort & ~hazard & ~flush; otherwise it stays in IDLE, so a hazard delays phase 0 without losing the instruction.
REQ-020 In PH1, sort_phase SHALL be 1, busy SHALL be 1, and freeze SHALL equal hazard & ~flush.
REQ-021 PH1 SHALL go to IDLE when ~hazard or flush; otherwise it stays in PH1.
REQ-022 done SHALL be 1 exactly in a PH1 cycle with ~hazard & ~flush.
REQ-023 sort_count SHALL increment on each done cycle.
REQ-024 sort_count SHALL saturate at 16'hFFFF with no wrap-around.
REQ-025 flush SHALL have priority over hazard in both states: no done, no count update, and a return to IDLE.
REQ-026 Latency SHALL be exactly 2 issue cycles per SORT with no hazard (phase 0 then phase 1), and 2 + N cycles with N total hazard cycles.
REQ-027 A SORT whose cond_pass = 0 SHALL be treated as a normal annulled instruction: no freeze, no state change.
REQ-028 Back-to-back SORTs SHALL be supported: after PH1 completes, the next fetched SORT enters phase 0 in the following cycle with no gap.
REQ-029 cond_pass SHALL be sampled only in IDLE; a change of SR during PH1 SHALL NOT abort phase 1.

Reset
REQ-030 On rst, the block SHALL immediately (asynchronously) set the state to IDLE and sort_count to 0.
REQ-031 With rst high, the outputs SHALL be sort_phase = 0, busy = 0, done = 0, sort_count = 0, and freeze = 0 (freeze follows IDLE decode, which is gated by instr_valid = 0 from the reset pipeline).
REQ-032 Reset asserted mid-PH1 SHALL abandon the SORT without a done pulse.

Structure
REQ-033 SORT_OPCODE, MODE_ARITH (2'b00) and the state enumeration (IDLE, PH1) SHALL reside in the shared package used by the control unit.
REQ-034 The saturating counter SHALL be one sub-module, sat_counter16 (ports: clk, rst, inc, count).
REQ-035 The FSM SHALL remain in the top-level module.
REQ-036 The total implementation SHALL be 120-400 lines.

Verification
REQ-037 Plain SORT with hazard = 0 -> cycle 0: freeze = 1, sort_phase = 0; cycle 1: sort_phase = 1, done = 1, freeze = 0; sort_count = 1.
REQ-038 SORT with hazard high for 2 cycles in IDLE and then 1 cycle in PH1 -> done asserts in cycle 4 only, and freeze is high in cycles 0-3.
REQ-039 flush in the PH1 cycle -> return to IDLE, done = 0, sort_count unchanged.
REQ-040 SORT with cond_pass = 0, and ADD (op_code 0100) -> freeze = 0, busy = 0, and the state stays IDLE.
REQ-041 rst pulse mid-PH1 -> state goes to IDLE immediately and sort_count goes to 0 without waiting for a clock edge.
REQ-042 sort_count preloaded to 16'hFFFE plus 3 SORTs -> the count reads 16'hFFFF and holds there.
